// File: rtl/mac_pkg.sv
// Shared widths, timeout default and the sequencer state encoding for the MAC initiator.
// Pure declarations; it adds no logic, latency or flow control.
package mac_pkg;

    localparam int DATA_WIDTH_D = 16;
    localparam int ACC_WIDTH_D  = 40;
    localparam int LEN_W_D      = 8;
    localparam int TIMEOUT_D    = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        ISSUE,
        WAIT,
        SETTLE,
        DONE
    } seq_state_t;

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mac_watchdog.sv
// Per-term watchdog: clear/enable counter; expired is combinational in the enabled cycle the count reaches TIMEOUT.
// No flow control; the counter saturates at TIMEOUT while left enabled.
module mac_watchdog
    import mac_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = wd_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // The n-th enabled cycle sees count == n-1, so this fires on wait cycle TIMEOUT.
    assign expired = en && (count == LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Command-driven dot-product initiator: clear, then per term fetch/start/wait; result 3 + N*(L+2) cycles after the command.
// Stalls in FETCH without op_valid; result beat holds until res_ready; a silent MAC aborts the command after TIMEOUT cycles.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D,
    parameter int LEN_W      = LEN_W_D,
    parameter int TIMEOUT    = TIMEOUT_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  mac_start,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_acc,
    input  logic                  mac_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_err
);

    seq_state_t       state;
    logic [LEN_W-1:0] remaining;
    logic             err;
    logic             wd_expired;

    mac_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ISSUE),
        .en      (state == WAIT),
        .expired (wd_expired)
    );

    // All handshake and MAC-drive outputs are registered and set on the transition into their state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            op_ready  <= 1'b0;
            mac_start <= 1'b0;
            mac_clr   <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            mac_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        remaining <= cmd_len;
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        mac_clr   <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (remaining == '0) begin
                        state <= SETTLE;
                    end else begin
                        op_ready <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (op_valid && op_ready) begin
                        mac_a     <= op_a;
                        mac_b     <= op_b;
                        op_ready  <= 1'b0;
                        mac_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A ready pulse in the timeout cycle still counts as a good term.
                    if (mac_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= SETTLE;
                        end else begin
                            op_ready <= 1'b1;
                            state    <= FETCH;
                        end
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The MAC folds in the last product on the ready edge, so the accumulator is final only now.
                    res_data  <= mac_acc;
                    res_err   <= err;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        err       <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC stub of configurable per-term latency.
module tb_mac_sequencer;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        mac_start;
    logic        mac_clr;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [39:0] mac_acc;
    logic        mac_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [39:0] res_data;
    logic        res_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic signed [15:0] va [8];
    logic signed [15:0] vb [8];

    // MAC stub: ready pulses stub_lat cycles after the start cycle; accumulator updates on that edge.
    logic [39:0]        acc_m;
    logic               busy_m;
    int                 cnt_m;
    int                 stub_lat = 3;
    logic               stub_en = 1'b1;
    logic signed [31:0] prod_m;

    assign prod_m    = $signed(mac_a) * $signed(mac_b);
    assign mac_ready = busy_m && stub_en && (cnt_m == stub_lat);
    assign mac_acc   = acc_m;

    always @(posedge clk) begin
        if (!rst_n) begin
            acc_m  <= '0;
            busy_m <= 1'b0;
            cnt_m  <= 0;
        end else begin
            if (mac_clr)
                acc_m <= '0;
            else if (mac_ready)
                acc_m <= acc_m + {{8{prod_m[31]}}, prod_m};
            if (mac_start) begin
                busy_m <= 1'b1;
                cnt_m  <= 1;
            end else if (mac_ready) begin
                busy_m <= 1'b0;
            end else if (busy_m) begin
                cnt_m <= cnt_m + 1;
            end
        end
    end

    mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_start (mac_start),
        .mac_clr   (mac_clr),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .mac_ready (mac_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; the cmd transfer cycle is cycle 0, cyc is the first cycle res_valid is seen.
    task automatic run_cmd(input int n, input int budget, output logic found, output logic [39:0] data,
                           output logic err, output int cyc, output int starts, output int clrs);
        int   idx;
        logic xfer;
        idx = 0; found = 1'b0; data = '0; err = 1'b0; cyc = -1; starts = 0; clrs = 0;
        cmd_valid = 1'b1;
        cmd_len   = 8'(n);
        op_valid  = (n > 0);
        op_a      = va[0];
        op_b      = vb[0];
        for (int t = 0; t <= budget; t++) begin
            if (mac_start) starts++;
            if (mac_clr) clrs++;
            if (res_valid) begin
                found = 1'b1; data = res_data; err = res_err; cyc = t;
                break;
            end
            xfer = op_valid && op_ready;
            @(negedge clk);
            cmd_valid = 1'b0;
            if (xfer) begin
                idx++;
                if (idx < n) begin
                    op_a = va[idx];
                    op_b = vb[idx];
                end else begin
                    op_valid = 1'b0;
                end
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic pop_result(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++;
        if (res_valid !== 1'b0) $display("FAIL %s_drop: res_valid=%b want 0", name, res_valid);
        else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL %s_cmd_ready: cmd_ready=%b want 1", name, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cmd_ready, op_ready, mac_start, mac_clr, res_valid, res_err} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, op_ready, mac_start, mac_clr, res_valid, res_err});
        else pass_cnt++;
        total_cnt++;
        if ({mac_a, mac_b, res_data} !== 72'd0)
            $display("FAIL reset_data: mac_a=%h mac_b=%h res_data=%h want 0", mac_a, mac_b, res_data);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic f; logic [39:0] d; logic e; int c, s, k;
        va[0] = 16'sd3; vb[0] = 16'sd4;
        run_cmd(1, 40, f, d, e, c, s, k);
        total_cnt++;
        if (f !== 1'b1 || d !== 40'd12 || e !== 1'b0)
            $display("FAIL single_result: found=%b data=%h err=%b want 1/00_0000_000c/0", f, d, e);
        else pass_cnt++;
        total_cnt++;
        if (c !== 8) $display("FAIL single_latency: cycle=%0d want 8", c);
        else pass_cnt++;
        total_cnt++;
        if (mac_a !== 16'd3 || mac_b !== 16'd4) $display("FAIL single_hold: mac_a=%h mac_b=%h want 3/4", mac_a, mac_b);
        else pass_cnt++;
        pop_result("single");
    endtask

    task automatic test_four_terms();
        logic f; logic [39:0] d; logic e; int c, s, k;
        for (int i = 0; i < 4; i++) begin
            va[i] = 16'(i + 1);
            vb[i] = 16'(i + 5);
        end
        run_cmd(4, 60, f, d, e, c, s, k);
        total_cnt++;
        if (d !== 40'd70 || e !== 1'b0) $display("FAIL four_result: data=%h err=%b want 70/0", d, e);
        else pass_cnt++;
        total_cnt++;
        if (s !== 4 || k !== 1) $display("FAIL four_pulses: starts=%0d clrs=%0d want 4/1", s, k);
        else pass_cnt++;
        total_cnt++;
        if (c !== 23) $display("FAIL four_latency: cycle=%0d want 23", c);
        else pass_cnt++;
        pop_result("four");
    endtask

    task automatic test_signed();
        logic f; logic [39:0] d; logic e; int c, s, k;
        va[0] = -16'sd3; vb[0] = 16'sd5;
        va[1] = 16'sd2;  vb[1] = -16'sd7;
        run_cmd(2, 40, f, d, e, c, s, k);
        total_cnt++;
        if (d !== 40'hFF_FFFF_FFE3 || c !== 13) $display("FAIL signed_result: data=%h cycle=%0d want ff_ffff_ffe3/13", d, c);
        else pass_cnt++;
        pop_result("signed");
    endtask

    task automatic test_back_to_back();
        logic f; logic [39:0] d; logic e; int c, s, k;
        run_cmd(0, 20, f, d, e, c, s, k);
        total_cnt++;
        if (d !== 40'd0 || c !== 3) $display("FAIL zero_result: data=%h cycle=%0d want 0/3", d, c);
        else pass_cnt++;
        total_cnt++;
        if (s !== 0 || k !== 1) $display("FAIL zero_pulses: starts=%0d clrs=%0d want 0/1", s, k);
        else pass_cnt++;
        pop_result("zero");
        va[0] = 16'sd2; vb[0] = 16'sd2;
        run_cmd(1, 40, f, d, e, c, s, k);
        total_cnt++;
        if (d !== 40'd4 || e !== 1'b0 || c !== 8) $display("FAIL b2b_result: data=%h err=%b cycle=%0d want 4/0/8", d, e, c);
        else pass_cnt++;
        pop_result("b2b");
    endtask

    task automatic test_timeout();
        logic f; logic [39:0] d; logic e; int c, s, k;
        stub_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            va[i] = 16'sd9;
            vb[i] = 16'sd9;
        end
        run_cmd(3, 100, f, d, e, c, s, k);
        total_cnt++;
        if (f !== 1'b1 || e !== 1'b1 || c !== 69) $display("FAIL timeout_result: found=%b err=%b cycle=%0d want 1/1/69", f, e, c);
        else pass_cnt++;
        total_cnt++;
        if (s !== 1 || d !== 40'd0) $display("FAIL timeout_abort: starts=%0d data=%h want 1/0", s, d);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 40'd0)
                $display("FAIL timeout_hold%0d: valid=%b err=%b data=%h want 1/1/0", i, res_valid, res_err, res_data);
            else pass_cnt++;
        end
        pop_result("timeout");
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL timeout_err_clear: res_err=%b want 0", res_err);
        else pass_cnt++;
        stub_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic f; logic [39:0] d; logic e; int c, s, k;
        cmd_valid = 1'b1; cmd_len = 8'd3;
        op_valid = 1'b1; op_a = 16'sd1; op_b = 16'sd1;
        repeat (10) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        total_cnt++;
        if (dut.state !== WAIT) $display("FAIL midrst_pre_state: state=%0d want WAIT", dut.state);
        else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op_valid = 1'b0;
        total_cnt++;
        if (dut.state !== IDLE || cmd_ready !== 1'b1 || res_valid !== 1'b0 || op_ready !== 1'b0)
            $display("FAIL midrst_state: state=%0d cmd_ready=%b res_valid=%b op_ready=%b want IDLE/1/0/0",
                     dut.state, cmd_ready, res_valid, op_ready);
        else pass_cnt++;
        va[0] = 16'sd6; vb[0] = 16'sd7;
        run_cmd(1, 40, f, d, e, c, s, k);
        total_cnt++;
        if (d !== 40'd42 || e !== 1'b0 || c !== 8) $display("FAIL midrst_result: data=%h err=%b cycle=%0d want 42/0/8", d, e, c);
        else pass_cnt++;
        pop_result("midrst");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_four_terms();
        test_signed();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Command-driven initiator for the MAC unit: it computes one signed dot product per command.
- Accepts a term count, then streams operand pairs to the MAC, one at a time.
- For each pair: pulses start, waits for the per-term ready pulse, then moves to the next pair.
- After the last term, returns the 40-bit accumulator as a result beat.
- Sits between an operand source (buffer/DMA) and the MAC top, owning the MAC's start/clr_acc/A_in/B_in drive and consuming its Accumulator/ready_mac.

Parameters:
DATA_WIDTH, 16, operand width (signed two's complement)
ACC_WIDTH, 40, accumulator/result width
LEN_W, 8, width of term-count field (max 255 terms)
TIMEOUT, 64, max cycles waited for mac_ready per term before abort

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset (sampled on clk rising edge; polarity and synchronicity fixed)
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command
cmd_len  in  LEN_W  number of terms N
op_valid  in  1  operand pair offered
op_ready  out  1  sequencer takes operand pair
op_a  in  DATA_WIDTH  multiplicand
op_b  in  DATA_WIDTH  multiplier
mac_start  out  1  one-cycle start pulse to MAC
mac_clr  out  1  one-cycle accumulator clear to MAC
mac_a  out  DATA_WIDTH  held multiplicand to MAC
mac_b  out  DATA_WIDTH  held multiplier to MAC
mac_acc  in  ACC_WIDTH  MAC accumulator
mac_ready  in  1  MAC per-term done pulse
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  ACC_WIDTH  dot-product result
res_err  out  1  result aborted by timeout

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; all outputs 0 except cmd_ready=1; counters and registers cleared. Reset mid-operation abandons the command; no result beat is produced.
- Handshakes: a transfer occurs when valid&ready are both high at a rising edge. Once asserted, res_valid/res_data/res_err hold until res_ready.
- IDLE: cmd_ready=1. On cmd transfer, latch N=cmd_len and go to CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle. Go to SETTLE if N==0, else FETCH.
- FETCH: op_ready=1. On op transfer, latch op_a/op_b into mac_a/mac_b and go to ISSUE. Stalls indefinitely while op_valid=0.
- ISSUE: mac_start=1 for exactly one cycle; watchdog cleared. Go to WAIT.
- WAIT: watchdog increments each cycle.
  - On mac_ready: decrement remaining count. If remaining was 1, go to SETTLE, else go to FETCH.
  - If the watchdog reaches TIMEOUT with no mac_ready: set err and go to SETTLE.
  - If mac_ready and the timeout coincide in the same cycle, mac_ready wins (no error).
- SETTLE: one cycle, required because the MAC accumulator updates on the edge where ready_mac is high. Capture mac_acc into res_data at the end of this cycle, then go to DONE.
- DONE: res_valid=1, res_err=err. On res_ready, clear res_valid/err and go to IDLE; cmd_ready reasserts the next cycle.
- mac_a/mac_b are held stable from ISSUE until the next FETCH transfer; they never change during WAIT.
- mac_ready seen outside WAIT is ignored.
- Arithmetic: no arithmetic is performed here; signedness and 40-bit wrap are the MAC's. res_data is mac_acc verbatim.
- Latency: let L = cycles from the mac_start cycle to the mac_ready cycle. With op_valid held high and a command accepted in cycle 0, res_valid rises in cycle 3 + N·(L+2). For N=0, res_valid rises in cycle 3.

Decomposition:
- Package mac_pkg: DATA_WIDTH/ACC_WIDTH defaults, seq_state_t enum {IDLE, CLEAR, FETCH, ISSUE, WAIT, SETTLE, DONE}, TIMEOUT default.
- One sub-module, mac_watchdog: clear/enable counter with an expired flag, sized to $clog2(TIMEOUT+1).
- FSM and datapath registers live in mac_sequencer.

Test Plan:
1. N=1, op (3,4) with real mac_top → res_data=12, res_err=0, res_valid at cycle 3+(L+2).
2. N=4, a=[1,2,3,4], b=[5,6,7,8] → res_data=70; exactly 4 mac_start pulses and 1 mac_clr pulse.
3. N=2, pairs (-3,5),(2,-7) → res_data=40'hFF_FFFF_FFE3 (-29).
4. N=0 → mac_clr pulse, no mac_start, res_valid in cycle 3, res_data=0; back-to-back second command (N=1, (2,2)) → 4, with no stale carry-over.
5. MAC stub never asserts mac_ready, N=3 → res_valid after TIMEOUT wait cycles with res_err=1; res_valid held 5 cycles under res_ready=0, then drops one cycle after res_ready=1.
6. rst_n low during WAIT of term 2 → next cycle state IDLE, cmd_ready=1, res_valid=0; a new command N=1 (6,7) → 42.
